// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry valid/ready skid register with registered handshakes, flush and async reset
module pipe_skid_reg #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] INIT_DATA = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [1:0]       level
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] main_q, skid_q;
  logic acc, dlv, ld_main, ld_skid;
  assign in_ready  = state != FULL;
  assign out_valid = state != EMPTY;
  assign out_data  = main_q;
  assign level     = state;
  assign acc       = in_valid && in_ready;
  assign dlv       = out_valid && out_ready;
  always_comb begin
    state_nxt = state;
    ld_main   = 1'b0;
    ld_skid   = 1'b0;
    state_nxt = flush ? EMPTY :
                state == EMPTY ? (acc ? ONE : EMPTY) :
                state == ONE   ? (acc && !dlv ? FULL : !acc && dlv ? EMPTY : ONE) :
                (dlv ? ONE : FULL);
    ld_main   = !flush && (state == FULL ? dlv : acc && (state == EMPTY || dlv));
    ld_skid   = !flush && state == ONE && acc && !dlv;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= INIT_DATA;
      skid_q <= INIT_DATA;
    end else begin
      state <= state_nxt;
      if (ld_main) main_q <= state == FULL ? skid_q : in_data;
      if (ld_skid) skid_q <= in_data;
    end
  end
endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the data path width in bits.
REQ-002 The module SHALL have parameter INIT_DATA, default 16'h0000 (WIDTH bits), giving the value driven on out_data after reset.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port flush, input, 1 bit: synchronous pipeline flush.
REQ-006 The module SHALL have port in_valid, input, 1 bit: the upstream producer presents in_data.
REQ-007 The module SHALL have port in_data, input, WIDTH bits: the upstream payload.
REQ-008 The module SHALL have port in_ready, output, 1 bit: the block can accept a beat this cycle.
REQ-009 The module SHALL have port out_valid, output, 1 bit: out_data holds a valid beat.
REQ-010 The module SHALL have port out_data, output, WIDTH bits: the downstream payload.
REQ-011 The module SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the beat.
REQ-012 The module SHALL have port level, output, 2 bits: current occupancy, 0 to 2.

Function
REQ-013 A beat SHALL be accepted upstream when in_valid && in_ready, and delivered downstream when out_valid && out_ready, both sampled at the rising edge of clk.
REQ-014 Storage SHALL be a main register driving out_data plus one skid register, tracked by states EMPTY (level=0), ONE (level=1) and FULL (level=2).
REQ-015 out_valid SHALL be 1 in ONE and FULL; in_ready SHALL be 1 in EMPTY and ONE; both SHALL be driven only from registered state, with no combinational path from out_ready or in_valid.
REQ-016 EMPTY transitions: an accept SHALL load main and go to ONE; otherwise the block SHALL stay in EMPTY.
REQ-017 ONE transitions:
- accept with delivery: main SHALL load in_data and the block SHALL stay in ONE.
- accept without delivery: skid SHALL load in_data and the block SHALL go to FULL.
- delivery without accept: the block SHALL go to EMPTY.
- neither: the block SHALL hold.
REQ-018 FULL transitions: on delivery, main SHALL load skid and the block SHALL go to ONE; otherwise the block SHALL hold; no accept is possible in FULL.
REQ-019 Latency: a beat accepted at edge N into an EMPTY block SHALL appear on out_data with out_valid=1 after edge N.
REQ-020 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-021 Beats SHALL leave in acceptance order, with no loss or duplication.
REQ-022 flush=1 at an edge SHALL force EMPTY and SHALL discard any simultaneous accept; the data registers MAY retain stale contents; flush SHALL take priority over every other event.
REQ-023 With in_valid=1 and out_ready=1 held every cycle, throughput SHALL be one beat per cycle.

Reset
REQ-024 While rst=1, asynchronously and regardless of clk, the block SHALL enter EMPTY with out_valid=0, in_ready=1, level=0, out_data=INIT_DATA and skid=INIT_DATA.
REQ-025 Assertion of rst mid-transfer SHALL discard all held beats; the first accept after rst deasserts SHALL behave as from EMPTY.

Verification
REQ-026 The bench SHALL cover: assert rst with out_ready=0 and the block FULL -> out_valid=0, in_ready=1, level=0, out_data=16'h0000 immediately, without a clk edge.
REQ-027 The bench SHALL cover: from EMPTY, in_data=16'h1234 with in_valid=1 for one edge, out_ready=0 -> out_valid=1, out_data=16'h1234, level=1 next cycle.
REQ-028 The bench SHALL cover: out_ready=0, push 16'hAAAA then 16'hBBBB -> level=2, in_ready=0, out_data=16'hAAAA; then raise out_ready -> 16'hAAAA and 16'hBBBB delivered on consecutive edges, then level=0.
REQ-029 The bench SHALL cover: in_valid=1 and out_ready=1 for 8 cycles with data 0..7 -> outputs 0..7 on 8 consecutive cycles, level constant at 1.
REQ-030 The bench SHALL cover: FULL with flush=1, in_valid=1, out_ready=1 at one edge -> level=0, out_valid=0, in_ready=1, and no beat from that edge ever appears.
REQ-031 The bench SHALL cover: random in_valid and out_ready for 10,000 cycles -> a scoreboard shows in-order, lossless delivery, out_data stable while stalled, and level always equal to accepts minus deliveries.
